// File: rtl/tone_arbiter.sv
// rtl/tone_arbiter.sv - fixed-priority arbiter sharing one square-wave tone generator
// Optional preemption of a playing note by a higher-priority request: TONE_ARB_PREEMPT_EN.
module tone_arbiter #(
  parameter int TICK_DIV = 6_250_000,
  parameter int DIV_W    = 21,
  parameter int DUR_W    = 8
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic [2:0]       iREQ,
  input  logic [DIV_W-1:0] iHALF0,
  input  logic [DIV_W-1:0] iHALF1,
  input  logic [DIV_W-1:0] iHALF2,
  input  logic [DUR_W-1:0] iDUR0,
  input  logic [DUR_W-1:0] iDUR1,
  input  logic [DUR_W-1:0] iDUR2,
  output logic [2:0]       oGNT,
  output logic [2:0]       oDONE,
  output logic             oBUSY,
  output logic             oSOUND
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAY    = 2'd1,
    RELEASE = 2'd2
  } stateT;

  stateT            state;
  stateT            stateNext;
  logic [1:0]       gSel;
  logic [1:0]       reqIdx;
  logic [2:0]       gMask;
  logic [PRE_W-1:0] preCnt;
  logic [DUR_W-1:0] tickCnt;
  logic [DUR_W-1:0] durLat;
  logic [DIV_W-1:0] toneCnt;
  logic [DIV_W-1:0] halfLat;
  logic [DIV_W-1:0] halfSel;
  logic [DUR_W-1:0] durSel;
  logic             tickWrap;
  logic             toneWrap;
  logic             noteEnd;
  logic             preempt;

  always_comb begin
    reqIdx = 2'd2;
    if (iREQ[1]) reqIdx = 2'd1;
    if (iREQ[0]) reqIdx = 2'd0;
  end

  always_comb begin
    halfSel = iHALF2;
    durSel  = iDUR2;
    case (reqIdx)
      2'd0: begin
        halfSel = iHALF0;
        durSel  = iDUR0;
      end
      2'd1: begin
        halfSel = iHALF1;
        durSel  = iDUR1;
      end
      default: ;
    endcase
  end

  assign gMask    = 3'b001 << gSel;
  assign tickWrap = (preCnt == PRE_LAST);
  assign toneWrap = (halfLat != '0) && (toneCnt == halfLat - DIV_W'(1));
  // Ending on the tick that would reach the duration keeps the grant at exactly DUR*TICK_DIV clocks.
  assign noteEnd  = (durLat == '0) || (tickWrap && (tickCnt + DUR_W'(1) == durLat));

`ifdef TONE_ARB_PREEMPT_EN
  assign preempt = |(iREQ & (gMask - 3'd1));
`else
  assign preempt = 1'b0;
`endif

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (|iREQ) stateNext = PLAY;
      PLAY: begin
        if (noteEnd)      stateNext = RELEASE;
        else if (preempt) stateNext = IDLE;
      end
      RELEASE: if (!(|(iREQ & gMask))) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state <= IDLE;
    else         state <= stateNext;
  end

  assign oGNT  = (state == PLAY) ? gMask : 3'b000;
  assign oBUSY = (state != IDLE);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      gSel    <= 2'd0;
      halfLat <= '0;
      durLat  <= '0;
      preCnt  <= '0;
      tickCnt <= '0;
      toneCnt <= '0;
      oDONE   <= 3'b000;
      oSOUND  <= 1'b0;
    end else begin
      oDONE <= 3'b000;
      case (state)
        IDLE: begin
          if (|iREQ) begin
            gSel    <= reqIdx;
            halfLat <= halfSel;
            durLat  <= durSel;
            preCnt  <= '0;
            tickCnt <= '0;
            toneCnt <= '0;
            oSOUND  <= 1'b0;
          end
        end
        PLAY: begin
          if (noteEnd) begin
            oDONE  <= gMask;
            oSOUND <= 1'b0;
          end else if (preempt) begin
            oSOUND <= 1'b0;
          end else begin
            preCnt <= tickWrap ? '0 : preCnt + PRE_W'(1);
            if (tickWrap) tickCnt <= tickCnt + DUR_W'(1);
            if (halfLat == '0) begin
              oSOUND <= 1'b0;
            end else if (toneWrap) begin
              toneCnt <= '0;
              oSOUND  <= ~oSOUND;
            end else begin
              toneCnt <= toneCnt + DIV_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tone_arbiter.sv
// tb/tb_tone_arbiter.sv - directed table-driven bench for tone_arbiter
// Expectations for the preemption sequence follow TONE_ARB_PREEMPT_EN.
module tb_tone_arbiter;

  localparam int TICK_DIV = 10;
  localparam int DIV_W    = 21;
  localparam int DUR_W    = 8;

  logic             iCLK = 1'b0;
  logic             iRST_N;
  logic [2:0]       iREQ;
  logic [DIV_W-1:0] iHALF0, iHALF1, iHALF2;
  logic [DUR_W-1:0] iDUR0, iDUR1, iDUR2;
  logic [2:0]       oGNT;
  logic [2:0]       oDONE;
  logic             oBUSY;
  logic             oSOUND;

  tone_arbiter #(.TICK_DIV(TICK_DIV), .DIV_W(DIV_W), .DUR_W(DUR_W)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iREQ(iREQ),
    .iHALF0(iHALF0), .iHALF1(iHALF1), .iHALF2(iHALF2),
    .iDUR0(iDUR0), .iDUR1(iDUR1), .iDUR2(iDUR2),
    .oGNT(oGNT), .oDONE(oDONE), .oBUSY(oBUSY), .oSOUND(oSOUND)
  );

  always #5 iCLK = ~iCLK;

  int nChecks = 0;
  int nFail   = 0;

  typedef struct {
    logic [2:0] req;
    int h0, h1, h2;
    int d0, d1, d2;
    logic [2:0] gnt;
    int len, rises, first, period;
  } vecT;

  vecT vecs[7];

  logic [2:0] gBit[6];
  int         gStart[6];
  int         gLen[6];
  logic [2:0] dBit[6];
  int         nG, nD;
  logic       monOk;

  task automatic check(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic setInputs(input int h0, input int h1, input int h2,
                           input int d0, input int d1, input int d2);
    iHALF0 = DIV_W'(h0); iHALF1 = DIV_W'(h1); iHALF2 = DIV_W'(h2);
    iDUR0  = DUR_W'(d0); iDUR1  = DUR_W'(d1); iDUR2  = DUR_W'(d2);
  endtask

  task automatic runNote(input vecT v, input int idx);
    int n, rises, first, lastRise, perBad, doneCnt, doneIdx, sndEnd;
    logic prevS;
    string tag;
    tag = $sformatf("v%0d", idx);
    setInputs(v.h0, v.h1, v.h2, v.d0, v.d1, v.d2);
    iREQ = v.req;
    step();
    check({tag, "_gnt"}, int'(oGNT), int'(v.gnt));
    // Latched values must be immune to later input changes.
    setInputs(7, 7, 7, 9, 9, 9);
    n = 0; rises = 0; first = -1; lastRise = -1; perBad = 0;
    doneCnt = 0; doneIdx = -1; sndEnd = -1; prevS = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (oGNT == v.gnt) n++;
      if (oSOUND && !prevS) begin
        if (first < 0) first = c;
        if (lastRise >= 0 && (c - lastRise) != v.period) perBad++;
        lastRise = c;
        rises++;
      end
      prevS = oSOUND;
      if (oDONE != 3'b000) begin
        doneCnt++;
        if (oDONE == v.gnt) doneIdx = c;
      end
      if (oGNT == 3'b000) begin
        sndEnd = int'(oSOUND);
        break;
      end
      step();
    end
    check({tag, "_len"}, n, v.len);
    check({tag, "_rises"}, rises, v.rises);
    check({tag, "_first"}, first, v.first);
    check({tag, "_period"}, perBad, 0);
    check({tag, "_done_cnt"}, doneCnt, 1);
    check({tag, "_done_at"}, doneIdx, v.len);
    check({tag, "_snd_end"}, sndEnd, 0);
    iREQ = 3'b000;
    check({tag, "_busy_rel"}, int'(oBUSY), 1);
    step();
    check({tag, "_busy_idle"}, int'(oBUSY), 0);
    check({tag, "_done_clr"}, int'(oDONE), 0);
    step();
  endtask

  task automatic monitor(input int maxCyc, input int injectAt);
    logic [2:0] prevG;
    prevG = 3'b000; nG = 0; nD = 0; monOk = 1'b0;
    for (int i = 0; i < 6; i++) begin
      gBit[i] = 3'b000; gStart[i] = -1; gLen[i] = 0; dBit[i] = 3'b000;
    end
    for (int c = 0; c < maxCyc; c++) begin
      if (oGNT != 3'b000 && oGNT != prevG && nG < 6) begin
        gBit[nG] = oGNT; gStart[nG] = c; nG++;
      end
      if (oGNT != 3'b000 && nG > 0) gLen[nG-1]++;
      if (oDONE != 3'b000) begin
        if (nD < 6) dBit[nD] = oDONE;
        nD++;
        iREQ = iREQ & ~oDONE;
      end
      if (c == injectAt) iREQ[0] = 1'b1;
      prevG = oGNT;
      if (iREQ == 3'b000 && !oBUSY) begin
        monOk = 1'b1;
        break;
      end
      step();
    end
  endtask

  initial begin
    vecs[0] = '{3'b010, 0, 3, 0, 0, 4, 0, 3'b010, 40, 7,  3, 6};
    vecs[1] = '{3'b001, 5, 0, 0, 1, 0, 0, 3'b001, 10, 1,  5, 10};
    vecs[2] = '{3'b001, 2, 0, 0, 0, 0, 0, 3'b001,  1, 0, -1, 4};
    vecs[3] = '{3'b100, 0, 0, 0, 0, 0, 2, 3'b100, 20, 0, -1, 0};
    vecs[4] = '{3'b100, 0, 0, 1, 0, 0, 1, 3'b100, 10, 5,  1, 2};
    vecs[5] = '{3'b110, 0, 4, 7, 0, 2, 3, 3'b010, 20, 2,  4, 8};
    vecs[6] = '{3'b011, 2, 5, 0, 1, 3, 0, 3'b001, 10, 2,  2, 4};

    iRST_N = 1'b0;
    iREQ   = 3'b000;
    setInputs(0, 0, 0, 0, 0, 0);
    #2;
    check("rst_gnt", int'(oGNT), 0);
    check("rst_done", int'(oDONE), 0);
    check("rst_busy", int'(oBUSY), 0);
    check("rst_sound", int'(oSOUND), 0);
    step();
    step();
    iRST_N = 1'b1;
    step();
    check("idle_busy", int'(oBUSY), 0);

    for (int i = 0; i < 7; i++) runNote(vecs[i], i);

    // Reset asserted in the middle of a sounding note.
    setInputs(0, 3, 0, 0, 4, 0);
    iREQ = 3'b010;
    step();
    for (int i = 0; i < 4; i++) step();
    check("mid_sound_hi", int'(oSOUND), 1);
    check("mid_gnt_hi", int'(oGNT), 2);
    #2;
    iRST_N = 1'b0;
    #1;
    check("mid_rst_sound", int'(oSOUND), 0);
    check("mid_rst_gnt", int'(oGNT), 0);
    check("mid_rst_done", int'(oDONE), 0);
    check("mid_rst_busy", int'(oBUSY), 0);
    iREQ = 3'b000;
    step();
    iRST_N = 1'b1;
    step();
    check("post_rst_busy", int'(oBUSY), 0);
    check("post_rst_done", int'(oDONE), 0);
    setInputs(0, 0, 0, 0, 0, 0);
    iREQ = 3'b100;
    step();
    check("post_rst_grant", int'(oGNT), 4);
    step();
    check("post_rst_done2", int'(oDONE), 4);
    iREQ = 3'b000;
    step();
    step();

    // Contention: all three requesters held high.
    setInputs(2, 2, 2, 1, 1, 1);
    iREQ = 3'b111;
    step();
    monitor(200, -1);
    check("cont_finished", int'(monOk), 1);
    check("cont_ngrants", nG, 3);
    check("cont_g0", int'(gBit[0]), 1);
    check("cont_g1", int'(gBit[1]), 2);
    check("cont_g2", int'(gBit[2]), 4);
    check("cont_len0", gLen[0], 10);
    check("cont_gap", gStart[1] - (gStart[0] + gLen[0]), 2);
    check("cont_start2", gStart[2], 24);
    check("cont_ndone", nD, 3);
    step();

    // Requester 0 arrives while requester 2 is playing.
    setInputs(3, 0, 2, 1, 0, 2);
    iREQ = 3'b100;
    step();
    monitor(300, 5);
    check("pre_finished", int'(monOk), 1);
`ifdef TONE_ARB_PREEMPT_EN
    check("pre_ngrants", nG, 3);
    check("pre_g0", int'(gBit[0]), 4);
    check("pre_len0", gLen[0], 6);
    check("pre_g1", int'(gBit[1]), 1);
    check("pre_start1", gStart[1], 7);
    check("pre_len1", gLen[1], 10);
    check("pre_g2", int'(gBit[2]), 4);
    check("pre_start2", gStart[2], 19);
    check("pre_len2", gLen[2], 20);
    check("pre_ndone", nD, 2);
    check("pre_d0", int'(dBit[0]), 1);
    check("pre_d1", int'(dBit[1]), 4);
`else
    check("pre_ngrants", nG, 2);
    check("pre_g0", int'(gBit[0]), 4);
    check("pre_len0", gLen[0], 20);
    check("pre_g1", int'(gBit[1]), 1);
    check("pre_start1", gStart[1], 22);
    check("pre_len1", gLen[1], 10);
    check("pre_ndone", nD, 2);
    check("pre_d0", int'(dBit[0]), 4);
    check("pre_d1", int'(dBit[1]), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/tone_arbiter.md
# tone_arbiter

Shares one square-wave tone generator between three sound requesters: melody player, key click and alarm. Fixed-priority arbitration, four-phase request/grant/done handshake, and a per-grant note duration measured in prescaled ticks. It sits between the note-sequencing logic and the speaker pin and owns the only driver of `oSOUND`.

## Interface
- `TICK_DIV`, default 6_250_000: clocks per duration tick.
- `DIV_W`, default 21: width of half-period words.
- `DUR_W`, default 8: width of duration words, in ticks.

Ports:
- `iCLK`  in  1  system clock; all logic is on the rising edge.
- `iRST_N`  in  1  asynchronous active-low reset.
- `iREQ`  in  3  request per requester; bit 0 has the highest priority.
- `iHALF0`, `iHALF1`, `iHALF2`  in  DIV_W each  half-period of the tone in clocks; 0 means a rest.
- `iDUR0`, `iDUR1`, `iDUR2`  in  DUR_W each  note length in ticks.
- `oGNT`  out  3  one-hot grant.
- `oDONE`  out  3  one-cycle completion pulse per requester.
- `oBUSY`  out  1  high in every state except IDLE.
- `oSOUND`  out  1  square wave to the speaker.

## Operation
- States: IDLE, PLAY, RELEASE.
- IDLE: if any `iREQ` bit is set, pick the lowest set index g.
  - Set `oGNT[g]`.
  - Latch `iHALFg` and `iDURg` into internal registers.
  - Clear the prescaler, the tick count and the tone counter; go to PLAY.
- PLAY, tick prescaler: counts 0..TICK_DIV-1. Its wrap is a tick; each tick increments the tick count.
- PLAY, tone counter, when the latched half-period is nonzero:
  - Counts 0..half-1.
  - At half-1 it wraps and toggles `oSOUND`, giving a period of exactly 2*half clocks.
  - `oSOUND` starts at 0 on entry to PLAY.
- PLAY, rest: when the latched half-period is 0, `oSOUND` is held at 0.
- PLAY, end of note: when the tick count reaches the latched duration:
  - Pulse `oDONE[g]` for one cycle.
  - Clear `oGNT[g]`, force `oSOUND` to 0, go to RELEASE.
- PLAY, zero duration: PLAY lasts one cycle, then DONE; no tone edge is produced.
- RELEASE: wait for `iREQ[g]`=0, then go to IDLE. Other requests are not evaluated in RELEASE.
- Requester rule: hold `iREQ`, `iHALF` and `iDUR` stable until `oDONE`, then drop `iREQ`. Input changes after the grant have no effect; the values latched at grant are used.
- Simultaneous requests: the lowest index wins. The losers keep `iREQ` high and are served in later IDLE passes.
- Dropping `iREQ[g]` during PLAY does not abort the note; it completes normally, and RELEASE then exits immediately.
- Widths: the tick count is DUR_W bits and never wraps, because it stops at the duration. The tone counter is DIV_W bits.

## Timing
- Reset: asynchronous; every output is 0 immediately. The FSM, prescaler, tick count, tone counter and latches are all 0, and the FSM is in IDLE.
- Reset asserted mid-note silences `oSOUND` with no DONE pulse.
- Grant latency: `iREQ` sampled high at edge k gives `oGNT` high and `oBUSY` high after edge k.
- First `oSOUND` rise: half clocks after the grant edge.
- Note length: `oGNT` is high for exactly DUR*TICK_DIV clocks, or 1 clock when DUR=0. `oDONE` rises at the edge that clears `oGNT`.
- Release latency: from the edge that samples `iREQ[g]` low, IDLE is entered at the next edge. A new grant can follow one cycle after that, so the minimum gap between grants is 2 clocks.

## Configuration
- Macro: `TONE_ARB_PREEMPT_EN`.
- Defined:
  - In PLAY, if any `iREQ` bit with index below g is set, the current note is aborted at that edge.
  - `oGNT[g]` drops with no `oDONE[g]` pulse, `oSOUND` goes to 0, and the FSM goes to IDLE.
  - The new winner is granted on the following edge.
  - The preempted requester keeps `iREQ` high and is later regranted with its full duration restarted.
- Undefined: no preemption; a note always runs to completion.

## Test plan
- Reset: `iRST_N`=0 mid-note at TICK_DIV=10 -> `oSOUND`, `oGNT`, `oDONE` and `oBUSY` go to 0 immediately; after release the FSM is in IDLE.
- Single note: TICK_DIV=10, `iREQ`=3'b010, `iHALF1`=3, `iDUR1`=4 -> `oGNT`=3'b010 for 40 clocks, `oSOUND` period of 6 clocks, one `oDONE[1]` pulse, then `oBUSY`=0 one cycle after `iREQ[1]` drops.
- Contention: `iREQ`=3'b111 held, each requester dropping its request after its DONE -> grants issued in order 0, 1, 2 with a 2-clock gap between grants.
- Boundaries:
  - `iDUR0`=0 -> `oGNT[0]` high for 1 clock, `oDONE[0]` pulse, `oSOUND` stays 0.
  - `iHALF2`=0, `iDUR2`=2 -> 20 silent clocks.
- Preempt on: `TONE_ARB_PREEMPT_EN` defined, requester 2 playing, `iREQ[0]` rises -> `oGNT[2]` drops with no `oDONE[2]`, `oGNT[0]` high 2 edges later; requester 2 is regranted after requester 0's RELEASE and plays its full duration.
- Preempt off: same stimulus without the macro -> requester 2 completes and pulses `oDONE[2]`, then requester 0 is granted.
